// File: rtl/tx_pkg.sv
// Shared definitions for the polyphase QPSK branch shaper: symbol codes,
// the default root-raised-cosine tap set and a constant-safe clog2.
package tx_pkg;

   // 2-bit symbol codes held in the symbol line; the MAC only ever adds,
   // subtracts or skips a coefficient, so no multipliers are needed.
   localparam logic [1:0] SYM_ZERO = 2'b00;
   localparam logic [1:0] SYM_POS  = 2'b01;
   localparam logic [1:0] SYM_NEG  = 2'b11;

   // Geometry of the default tap set.
   localparam int RRC_OS     = 4;
   localparam int RRC_NBAUD  = 6;
   localparam int RRC_COEF_W = 8;

   // RRC, roll-off ~0.35, 4 samples/symbol over 6 symbols, peak scaled to 62.
   // Tap t lives at bits [t*8 +: 8]. The response is symmetric, so the
   // listing order (tap 23 first) reads the same either way.
   localparam logic [RRC_OS*RRC_NBAUD*RRC_COEF_W-1:0] RRC_COEF = {
      8'h01, 8'h03, 8'h04, 8'h01, 8'hFA, 8'hF5, 8'hF6, 8'hFE,
      8'h0E, 8'h21, 8'h33, 8'h3E, 8'h3E, 8'h33, 8'h21, 8'h0E,
      8'hFE, 8'hF6, 8'hF5, 8'hFA, 8'h01, 8'h04, 8'h03, 8'h01
   };

   // Ceiling log2, usable in parameter expressions; returns at least 1 so
   // derived index ports never collapse to zero width.
   function automatic int clog2(input int value);
      int r;
      r = 1;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/tx_polyphase_mac.sv
// Combinational multiply-free MAC for one polyphase branch: for the given
// phase p it sums sym[k]*COEF[k*OS+p] over the NBAUD symbols of the line.
module tx_polyphase_mac
   import tx_pkg::*;
#(
   parameter int OS     = 4,
   parameter int NBAUD  = 6,
   parameter int COEF_W = 8,
   parameter logic [OS*NBAUD*COEF_W-1:0] COEF = RRC_COEF,
   localparam int PH_W  = clog2(OS),
   localparam int ACC_W = COEF_W + clog2(NBAUD) + 1
) (
   input  logic [2*NBAUD-1:0]       i_sym,
   input  logic [PH_W-1:0]          i_phase,
   output logic signed [ACC_W-1:0]  o_acc
);

   // Index width that exactly addresses the flat coefficient vector.
   localparam int IDX_W = clog2(OS*NBAUD*COEF_W);

   // Running partial sums; psum[k+1] includes the term of symbol k.
   logic signed [ACC_W-1:0] psum [NBAUD+1];

   assign psum[0] = '0;

   for (genvar k = 0; k < NBAUD; k++) begin : g_tap
      logic [IDX_W-1:0]          base;
      logic signed [COEF_W-1:0]  coef;
      logic signed [ACC_W-1:0]   coef_ext;
      logic [1:0]                sym;
      logic signed [ACC_W-1:0]   term;

      // Symbol k sees tap k*OS+p for the branch currently being computed.
      assign base     = IDX_W'((k*OS + int'(i_phase)) * COEF_W);
      assign coef     = COEF[base +: COEF_W];
      assign coef_ext = ACC_W'(coef);
      assign sym      = i_sym[2*k +: 2];

      // +coef, -coef or nothing depending on the symbol code.
      assign term = (sym == SYM_POS) ? coef_ext :
                    (sym == SYM_NEG) ? -coef_ext : '0;

      assign psum[k+1] = psum[k] + term;
   end

   assign o_acc = psum[NBAUD];

endmodule

// File: rtl/tx_polyphase_shaper.sv
// QPSK branch transmitter: takes one bit per OS clocks, maps it to +1/-1,
// pulse-shapes it with a polyphase FIR and emits one saturated sample per
// enabled clock. Two register stages: MAC result, then shifted/saturated
// output, so a symbol's tap j contribution leaves two clocks after it is
// accepted plus j.
module tx_polyphase_shaper
   import tx_pkg::*;
#(
   parameter int OS     = 4,
   parameter int NBAUD  = 6,
   parameter int COEF_W = 8,
   parameter int OUT_W  = 8,
   parameter int SHIFT  = 0,
   parameter logic [OS*NBAUD*COEF_W-1:0] COEF = RRC_COEF,
   localparam int PH_W  = clog2(OS),
   localparam int ACC_W = COEF_W + clog2(NBAUD) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_enable,
   input  logic                     i_valid,
   input  logic                     i_bit,
   output logic                     o_ready,
   output logic signed [OUT_W-1:0]  o_data,
   output logic                     o_valid,
   output logic [PH_W-1:0]          o_phase,
   output logic                     o_underrun
);

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS - 1);
   localparam int              Y_MAX   = (2 ** (OUT_W - 1)) - 1;
   localparam int              Y_MIN   = -(2 ** (OUT_W - 1));

   // Phase counter, symbol line (sym[0] in the two LSBs) and pipeline.
   logic [PH_W-1:0]          phase_q, phase_d;
   logic [2*NBAUD-1:0]       sym_q, sym_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [PH_W-1:0]          acc_ph_q, acc_ph_d;
   logic signed [OUT_W-1:0]  data_q, data_d;
   logic [PH_W-1:0]          out_ph_q, out_ph_d;
   logic                     valid_q, valid_d;
   logic [1:0]               fill_q, fill_d;

   logic                     slot;
   logic [1:0]               new_sym;
   logic [PH_W-1:0]          mac_ph;
   logic signed [ACC_W-1:0]  mac_acc;
   logic signed [ACC_W-1:0]  shifted;
   logic signed [31:0]       shifted_w;
   logic signed [OUT_W-1:0]  sat_val;

   // Handshake: a bit is taken on a clock edge where i_valid & o_ready.
   // o_ready is high only in the phase-0 slot of an enabled, non-reset
   // cycle; i_valid outside that slot is simply ignored and the source is
   // never held off beyond o_ready. A phase-0 slot without i_valid inserts
   // a zero symbol and raises o_underrun for that cycle.
   assign slot       = (phase_q == '0);
   assign o_ready    = i_enable & slot & rst;
   assign o_underrun = o_ready & ~i_valid;
   assign new_sym    = i_valid ? (i_bit ? SYM_NEG : SYM_POS) : SYM_ZERO;

   // The MAC works on the phase slot that has just been filled, which is
   // one behind the free-running counter.
   assign mac_ph = (phase_q == '0) ? PH_LAST : phase_q - PH_W'(1);

   tx_polyphase_mac #(
      .OS     (OS),
      .NBAUD  (NBAUD),
      .COEF_W (COEF_W),
      .COEF   (COEF)
   ) u_mac (
      .i_sym   (sym_q),
      .i_phase (mac_ph),
      .o_acc   (mac_acc)
   );

   assign shifted   = acc_q >>> SHIFT;
   assign shifted_w = 32'(shifted);

   // Clamp the scaled accumulator into the signed output range.
   always_comb begin
      sat_val = OUT_W'(shifted_w);
      if (shifted_w > Y_MAX) begin
         sat_val = OUT_W'(Y_MAX);
      end else if (shifted_w < Y_MIN) begin
         sat_val = OUT_W'(Y_MIN);
      end
   end

   // Next state: everything advances only on enabled clocks, otherwise holds.
   always_comb begin
      phase_d  = phase_q;
      sym_d    = sym_q;
      acc_d    = acc_q;
      acc_ph_d = acc_ph_q;
      data_d   = data_q;
      out_ph_d = out_ph_q;
      valid_d  = 1'b0;
      fill_d   = fill_q;
      if (i_enable) begin
         phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
         if (slot) begin
            sym_d = {sym_q[2*NBAUD-3:0], new_sym};
         end
         acc_d    = mac_acc;
         acc_ph_d = mac_ph;
         data_d   = sat_val;
         out_ph_d = acc_ph_q;
         valid_d  = (fill_q == 2'd2);
         if (fill_q != 2'd2) begin
            fill_d = fill_q + 2'd1;
         end
      end
   end

   // State register; reset clears symbols in flight and the whole pipeline.
   always_ff @(posedge clk) begin
      if (!rst) begin
         phase_q  <= '0;
         sym_q    <= '0;
         acc_q    <= '0;
         acc_ph_q <= '0;
         data_q   <= '0;
         out_ph_q <= '0;
         valid_q  <= 1'b0;
         fill_q   <= '0;
      end else begin
         phase_q  <= phase_d;
         sym_q    <= sym_d;
         acc_q    <= acc_d;
         acc_ph_q <= acc_ph_d;
         data_q   <= data_d;
         out_ph_q <= out_ph_d;
         valid_q  <= valid_d;
         fill_q   <= fill_d;
      end
   end

   assign o_data  = data_q;
   assign o_phase = out_ph_q;
   assign o_valid = valid_q;

endmodule

// File: tb/tb_tx_polyphase_shaper.sv
// Bench for tx_polyphase_shaper: three instances share the stimulus
// (ramp taps, all-127 taps, default RRC taps). Expected samples come from
// an upsample-and-convolve reference over the symbols the bench handed in.
module tb_tx_polyphase_shaper;
   import tx_pkg::*;

   localparam int OS     = 4;
   localparam int NBAUD  = 6;
   localparam int COEF_W = 8;
   localparam int OUT_W  = 8;
   localparam int N_TAPS = OS * NBAUD;

   localparam int M_IDLE   = 0;
   localparam int M_IMPULSE = 1;
   localparam int M_SAT    = 2;
   localparam int M_STREAM = 3;

   function automatic logic [N_TAPS*COEF_W-1:0] make_coef(input int kind);
      logic [N_TAPS*COEF_W-1:0] v;
      v = '0;
      for (int t = 0; t < N_TAPS; t++) begin
         v[t*COEF_W +: COEF_W] = (kind == 0) ? COEF_W'(t + 1) : COEF_W'(127);
      end
      return v;
   endfunction

   localparam logic [N_TAPS*COEF_W-1:0] RAMP_COEF = make_coef(0);
   localparam logic [N_TAPS*COEF_W-1:0] SAT_COEF  = make_coef(1);

   // clock / reset / shared inputs
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic i_enable = 1'b0;
   logic i_valid = 1'b0;
   logic i_bit = 1'b0;

   logic                    o_ready    [3];
   logic signed [OUT_W-1:0] o_data     [3];
   logic                    o_valid    [3];
   logic [1:0]              o_phase    [3];
   logic                    o_underrun [3];

   always #5 clk = ~clk;

   tx_polyphase_shaper #(.COEF(RAMP_COEF)) u_dut_ramp (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_valid(i_valid), .i_bit(i_bit),
      .o_ready(o_ready[0]), .o_data(o_data[0]), .o_valid(o_valid[0]),
      .o_phase(o_phase[0]), .o_underrun(o_underrun[0]));

   tx_polyphase_shaper #(.COEF(SAT_COEF)) u_dut_sat (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_valid(i_valid), .i_bit(i_bit),
      .o_ready(o_ready[1]), .o_data(o_data[1]), .o_valid(o_valid[1]),
      .o_phase(o_phase[1]), .o_underrun(o_underrun[1]));

   tx_polyphase_shaper u_dut_rrc (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_valid(i_valid), .i_bit(i_bit),
      .o_ready(o_ready[2]), .o_data(o_data[2]), .o_valid(o_valid[2]),
      .o_phase(o_phase[2]), .o_underrun(o_underrun[2]));

   // scoreboard state
   int n_cmp = 0;
   int n_bad = 0;
   int sel = 0;
   int mode = M_IDLE;
   int m = 0;
   int ur_cnt = 0;
   int coef_m [N_TAPS];
   int sym_hist [$];
   logic [OUT_W-1:0] exp_q [$];
   logic [OUT_W-1:0] exp_v;
   logic [8:0] prbs = 9'b010101011;
   bit gap_done;

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic load_coef(input logic [N_TAPS*COEF_W-1:0] v);
      logic signed [COEF_W-1:0] c;
      for (int t = 0; t < N_TAPS; t++) begin
         c = v[t*COEF_W +: COEF_W];
         coef_m[t] = int'(c);
      end
   endtask

   // Sample after enabled edge me: symbols sit on every OS-th edge of an
   // otherwise zero stream, convolved with the taps, delayed by two edges.
   function automatic int exp_y(input int me);
      int acc;
      int n;
      acc = 0;
      for (int j = 0; j < N_TAPS; j++) begin
         n = me - 2 - j;
         if (n >= 0 && (n % OS) == 0 && (n / OS) < sym_hist.size()) begin
            acc += sym_hist[n / OS] * coef_m[j];
         end
      end
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
      return acc;
   endfunction

   // One clock: drive inputs, check the handshake, clock, check outputs.
   task automatic cyc(input bit en);
      bit slot0;
      bit v;
      bit b;
      int s;
      slot0 = ((m % OS) == 0);
      v = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      if (slot0) begin
         s = sym_hist.size();
         case (mode)
            M_IMPULSE: begin v = (s == 0); b = 1'b0; end
            M_SAT:     begin v = 1'b1; b = (s < 6); end
            M_STREAM:  begin v = 1'b1; b = prbs[8]; end
            default:   begin v = 1'b0; b = 1'b0; end
         endcase
      end
      i_enable = en;
      i_valid  = v;
      i_bit    = b;
      #1;
      check_val("o_ready", int'(o_ready[sel]), int'(en && slot0));
      check_val("o_underrun", int'(o_underrun[sel]), int'(en && slot0 && !v));
      if (o_underrun[sel]) ur_cnt++;
      @(posedge clk);
      if (en) begin
         if (slot0) begin
            sym_hist.push_back(v ? (b ? -1 : 1) : 0);
            if (mode == M_STREAM && v) prbs = {prbs[7:0], prbs[8] ^ prbs[4]};
         end
         m++;
      end
      #1;
      check_val("o_valid", int'(o_valid[sel]), int'(en && m >= 3));
      check_val("o_data", int'(o_data[sel]), exp_y(m - 1));
      if (m >= 2) check_val("o_phase", int'(o_phase[sel]), (m - 3 + OS) % OS);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      for (int i = 0; i < n; i++) begin
         i_enable = 1'b1;
         i_valid  = 1'b1;
         i_bit    = 1'($urandom_range(0, 1));
         #1;
         check_val("rst_ready", int'(o_ready[sel]), 0);
         check_val("rst_underrun", int'(o_underrun[sel]), 0);
         @(posedge clk);
         #1;
         check_val("rst_data", int'(o_data[sel]), 0);
         check_val("rst_valid", int'(o_valid[sel]), 0);
         check_val("rst_phase", int'(o_phase[sel]), 0);
      end
      rst = 1'b1;
      m = 0;
      sym_hist.delete();
      prbs = 9'b010101011;
   endtask

   initial begin
      // reset held 4 clocks with i_valid high
      sel = 0;
      load_coef(RAMP_COEF);
      do_reset(4);

      // impulse through ramp taps: 1..24 from E0+2, then zeros
      mode = M_IMPULSE;
      ur_cnt = 0;
      for (int e = 0; e < 40; e++) begin
         exp_q.push_back((e >= 2 && e <= 25) ? OUT_W'(e - 1) : OUT_W'(0));
      end
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1);
         if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            check_val("imp_seq", int'(o_data[0]), int'($signed(exp_v)));
         end
      end
      check_val("imp_underruns", ur_cnt, 9);

      // saturation: six -1 symbols, then +1 symbols, all taps 127
      do_reset(2);
      sel = 1;
      load_coef(SAT_COEF);
      mode = M_SAT;
      for (int i = 0; i < 50; i++) begin
         cyc(1'b1);
         if (m == 23) check_val("sat_neg", int'(o_data[1]), -128);
         if (m == 47) check_val("sat_pos", int'(o_data[1]), 127);
      end

      // prbs9 stream through the default taps with a 7-clock enable gap
      do_reset(2);
      sel = 2;
      load_coef(RRC_COEF);
      mode = M_STREAM;
      ur_cnt = 0;
      gap_done = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!gap_done && i >= 300 && (m % OS) == 2) begin
            for (int g = 0; g < 7; g++) cyc(1'b0);
            gap_done = 1'b1;
         end
         cyc(1'b1);
         if (m == 3) check_val("stream_first", int'(o_data[2]), 1);
      end
      check_val("stream_underruns", ur_cnt, 0);

      // reset at phase 3 mid-stream, then a fresh start
      for (int i = 0; i < 8 && (m % OS) != 3; i++) cyc(1'b1);
      check_val("pre_reset_phase", m % OS, 3);
      do_reset(3);
      for (int i = 0; i < 120; i++) begin
         cyc(1'b1);
         if (m == 2) check_val("restart_zero", int'(o_data[2]), 0);
         if (m == 3) check_val("restart_first", int'(o_data[2]), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
